fluid_board_soc_input_ctrl: RTL and testbench
=============================================

# fluid_board_soc_input_ctrl

Debounced, edge-capturing interrupt controller for the fluid board's discrete digital inputs (level switches, leak sensors, pump-fault lines). Sits between the raw `in_port` pins and the Nios II Avalon-MM bus. Synchronizes and filters each input, latches qualified edges into a sticky capture register, and raises a single masked `irq`. Replaces direct level-sensitive polling of the pins.

## Interface
- `WIDTH`, 4: number of input lines, 1..16.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable samples required to accept a new level, 1..2^`CNT_W`.
- `CNT_W`, 16: debounce counter width per input.

- `clk` in 1: system clock; all logic on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 3: Avalon word address.
- `chipselect` in 1: Avalon slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: level interrupt to CPU.
- `in_port` in `WIDTH`: asynchronous raw inputs.

## Operation
- Register map; unused bits read 0, writes ignored:
  - 0 DATA (RO): debounced levels `[WIDTH-1:0]`.
  - 1 RAW (RO): synchronizer output `[WIDTH-1:0]`.
  - 2 IRQ_MASK (RW): per-input enable.
  - 3 EDGE_CAP (R/W1C): sticky edge flags. Writing 1 clears the bit; writing 0 has no effect.
  - 4 EDGE_SEL (RW): 2 bits per input at `[2i+1:2i]`. 00 = off, 01 = rising, 10 = falling, 11 = both.
  - 5–7: read 0.
- Synchronizer: two flops per bit, `sync1` then `sync2`.
- Per-bit debounce FSM, two states:
  - STABLE (`sync2 == deb`): counter held at 0.
  - PENDING (`sync2 != deb`): counter increments each cycle.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while still PENDING: `deb <= sync2`, counter clears, return to STABLE.
  - If `sync2` returns to `deb` before then: counter clears with no update. Glitches shorter than `DEBOUNCE_CYCLES` are rejected.
- Edge capture:
  - EDGE_CAP[i] sets in the same clock that `deb[i]` changes, if the direction matches EDGE_SEL[i].
  - If a hardware set and a W1C of the same bit occur in one cycle, the set wins.
  - EDGE_SEL changes affect only subsequent edges; existing flags are kept.
- `irq = |(EDGE_CAP & IRQ_MASK)`: combinational from registers, so no glitch from `in_port`.
- Reset (any time, including mid-debounce) clears:
  - `sync1`, `sync2`, `deb`, counters, IRQ_MASK, EDGE_CAP, EDGE_SEL, `readdata`.
  - Consequence: an input held high through reset produces one rising edge after release, which is captured only if EDGE_SEL is already enabled at that moment.

## Timing
- Reads: `readdata` is registered every cycle from `address` regardless of `chipselect`; 1-cycle read latency, no wait states.
- Writes: take effect on the edge where `chipselect && !write_n`. Read-back is visible on the next cycle's read.
- Input latency: new level first sampled by `sync1` at edge E0. `deb` updates at edge E(1+`DEBOUNCE_CYCLES`). EDGE_CAP updates at the same edge. `irq` asserts immediately after it, if masked in.
- IRQ_MASK write: affects `irq` the cycle after the write edge.
- W1C write: deasserts `irq` the cycle after the write edge, unless a new edge lands on that same edge.
- Counter must not wrap. Widths with `DEBOUNCE_CYCLES > 2^CNT_W` are illegal; a synthesis-time check fails them.

## Configuration
- `FLUID_INPUT_DEBOUNCE_EN` defined: debounce counters and FSM are present as described.
- Not defined:
  - `deb <= sync2` every cycle; `DEBOUNCE_CYCLES` and `CNT_W` are ignored and no counters are instantiated.
  - Latency equals the `DEBOUNCE_CYCLES = 1` case: `deb` at E2.
  - Register map and edge/irq behaviour are unchanged.

## Test plan
Bench uses `DEBOUNCE_CYCLES = 4` with the macro defined, unless noted.
- Reset values: assert `reset` asynchronously mid-cycle -> `irq = 0` and `readdata = 0` immediately; all registers read 0 after release.
- Rising edge with irq: set EDGE_SEL = 0x01 and IRQ_MASK = 0x1, drive `in_port[0]` high at E0 -> DATA = 0x1 and EDGE_CAP = 0x1 at E5; `irq = 1` after E5. Write 0x1 to addr 3 -> `irq = 0` next cycle.
- Glitch rejection: 3-cycle high pulse on `in_port[1]` -> DATA, RAW-derived edges and EDGE_CAP stay 0; 4-cycle pulse -> rising then falling edge accepted. With EDGE_SEL[3:2] = 11, EDGE_CAP[1] = 1.
- Set/clear collision: schedule W1C of bit 2 on the same edge that `deb[2]` rises with rising selected -> EDGE_CAP[2] reads 1 afterwards.
- Masking: edge captured with IRQ_MASK = 0 -> `irq = 0`, EDGE_CAP = 1. Write IRQ_MASK = 1 -> `irq = 1` next cycle.
- Macro undefined build: drive `in_port[3]` high at E0 -> DATA[3] = 1 at E2; 1-cycle pulse is captured.

Source files
------------

// File: rtl/fluid_board_soc_input_ctrl.sv
// -----------------------------------------------------------------------------
// fluid_board_soc_input_ctrl
//
// Debounced, edge-capturing interrupt controller for the fluid board's discrete
// inputs (level switches, leak sensors, pump-fault lines). Each raw pin is
// double-flop synchronized, debounced, and its qualified edges are latched in a
// sticky capture register that drives one masked level interrupt.
//
// Build option: define FLUID_INPUT_DEBOUNCE_EN to include the per-input
// debounce counters. Without it the debounced level simply follows the
// synchronizer output (same timing as DEBOUNCE_CYCLES = 1).
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   address     Avalon word address (0 DATA, 1 RAW, 2 IRQ_MASK, 3 EDGE_CAP W1C,
//               4 EDGE_SEL, 5-7 read 0)
//   chipselect  Avalon slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data (1-cycle latency, no wait states)
//   irq         level interrupt, |(EDGE_CAP & IRQ_MASK)
//   in_port     asynchronous raw inputs
// -----------------------------------------------------------------------------
module fluid_board_soc_input_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    input  logic [WIDTH-1:0]  in_port
);

    // Reject configurations whose debounce counter would have to wrap.
    generate
        if (WIDTH < 1 || WIDTH > 16 || DEBOUNCE_CYCLES < 1 ||
            64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W)) begin : g_bad_cfg
            $error("fluid_board_soc_input_ctrl: illegal WIDTH/DEBOUNCE_CYCLES/CNT_W");
        end
    endgenerate

    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_deb;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_cap;
    logic [2*WIDTH-1:0] r_sel;
    logic [31:0]        r_readdata;

    logic [WIDTH-1:0]   w_deb_nxt;
    logic [WIDTH-1:0]   w_rise;
    logic [WIDTH-1:0]   w_fall;
    logic [WIDTH-1:0]   w_set;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_cap_nxt;
    logic [31:0]        w_rdata_nxt;
    logic               w_wr;
    logic               w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_unused_wdata = &{1'b0, writedata};

`ifdef FLUID_INPUT_DEBOUNCE_EN
    typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0][CNT_W-1:0] w_cnt_nxt;

    // State is implied by sync2 vs deb; the counter only runs while they differ
    // and is cleared whenever the input falls back to the accepted level.
    always_comb begin
        deb_state_t v_state;
        w_deb_nxt = r_deb;
        w_cnt_nxt = '0;
        v_state   = ST_STABLE;
        for (int i = 0; i < WIDTH; i++) begin
            v_state = (r_sync2[i] != r_deb[i]) ? ST_PENDING : ST_STABLE;
            case (v_state)
                ST_PENDING: begin
                    if (r_cnt[i] == LAST_CNT) begin
                        w_deb_nxt[i] = r_sync2[i];
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
                    end
                end
                default: w_cnt_nxt[i] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    always_comb begin
        w_deb_nxt = r_sync2;
    end
`endif

    // Edges are taken from the level about to be loaded into deb, so the
    // capture flag sets on the same edge that deb changes.
    assign w_rise = w_deb_nxt & ~r_deb;
    assign w_fall = ~w_deb_nxt & r_deb;

    always_comb begin
        w_set = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_set[i] = (w_rise[i] & r_sel[2*i]) | (w_fall[i] & r_sel[2*i+1]);
        end
    end

    // Hardware set is OR-ed in after the W1C so a coincident set wins.
    assign w_clr     = (w_wr && address == 3'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_cap_nxt = (r_cap & ~w_clr) | w_set;

    always_comb begin
        w_rdata_nxt = '0;
        case (address)
            3'd0:    w_rdata_nxt[WIDTH-1:0]   = r_deb;
            3'd1:    w_rdata_nxt[WIDTH-1:0]   = r_sync2;
            3'd2:    w_rdata_nxt[WIDTH-1:0]   = r_mask;
            3'd3:    w_rdata_nxt[WIDTH-1:0]   = r_cap;
            3'd4:    w_rdata_nxt[2*WIDTH-1:0] = r_sel;
            default: w_rdata_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_mask     <= '0;
            r_cap      <= '0;
            r_sel      <= '0;
            r_readdata <= '0;
        end else begin
            r_sync1    <= in_port;
            r_sync2    <= r_sync1;
            r_deb      <= w_deb_nxt;
            r_cap      <= w_cap_nxt;
            r_readdata <= w_rdata_nxt;
            if (w_wr && address == 3'd2) r_mask <= writedata[WIDTH-1:0];
            if (w_wr && address == 3'd4) r_sel  <= writedata[2*WIDTH-1:0];
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_fluid_board_soc_input_ctrl.sv
module tb_fluid_board_soc_input_ctrl;

`ifdef FLUID_INPUT_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1;
`endif

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  in_port;

    int total = 0;
    int bad   = 0;

    fluid_board_soc_input_ctrl #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .irq(irq), .in_port(in_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    endtask

    task automatic rdchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address = a;
        tick();
        chk(tag, readdata, exp);
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Power-on reset values
        chk("por_irq", {31'b0, irq}, 32'h0);
        for (int a = 0; a < 8; a++) rdchk($sformatf("por_reg%0d", a), 3'(a), 32'h0);

        // Rising edge on bit 0 with irq enabled
        wr(3'd4, 32'h1);
        wr(3'd2, 32'h1);
        in_port = 4'b0001;
        repeat (DB + 1) tick();
        chk("rise_irq_early", {31'b0, irq}, 32'h0);
        tick();
        chk("rise_irq_set", {31'b0, irq}, 32'h1);
        rdchk("rise_data", 3'd0, 32'h1);
        rdchk("rise_cap", 3'd3, 32'h1);
        rdchk("rise_raw", 3'd1, 32'h1);
        wr(3'd3, 32'h1);
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        rdchk("w1c_cap", 3'd3, 32'h0);
        in_port = 4'b0000;
        repeat (DB + 4) tick();
        rdchk("fall_data", 3'd0, 32'h0);
        rdchk("fall_nocap", 3'd3, 32'h0);

        // Glitch rejection on bit 1, both edges selected
        wr(3'd4, 32'h0D);
        in_port = 4'b0010;
        repeat (3) tick();
        in_port = 4'b0000;
        repeat (DB + 6) tick();
        rdchk("glitch3_data", 3'd0, 32'h0);
        rdchk("glitch3_cap", 3'd3, (DB <= 3) ? 32'h2 : 32'h0);
        wr(3'd3, 32'hF);
        in_port = 4'b0010;
        repeat (4) tick();
        in_port = 4'b0000;
        repeat (2) tick();
        rdchk("pulse4_data_hi", 3'd0, 32'h2);
        repeat (DB + 6) tick();
        rdchk("pulse4_data_lo", 3'd0, 32'h0);
        rdchk("pulse4_cap", 3'd3, 32'h2);
        chk("pulse4_irq_masked", {31'b0, irq}, 32'h0);

        // Set/clear collision on bit 2: W1C lands on the capture edge
        wr(3'd3, 32'hF);
        wr(3'd4, 32'h1D);
        in_port = 4'b0100;
        repeat (DB + 1) tick();
        wr(3'd3, 32'h4);
        rdchk("collide_cap", 3'd3, 32'h4);

        // Masking: captured but masked, then unmasked
        chk("mask_irq_off", {31'b0, irq}, 32'h0);
        wr(3'd2, 32'h5);
        chk("mask_irq_on", {31'b0, irq}, 32'h1);
        rdchk("mask_rd", 3'd2, 32'h5);

        // Asynchronous reset mid-cycle
        in_port = 4'b0000;
        repeat (DB + 4) tick();
        rdchk("pre_rst_cap", 3'd3, 32'h4);
        #3;
        reset = 1'b1;
        #1;
        chk("arst_irq", {31'b0, irq}, 32'h0);
        chk("arst_rdata", readdata, 32'h0);
        repeat (2) tick();
        reset = 1'b0;
        for (int a = 0; a < 8; a++) rdchk($sformatf("arst_reg%0d", a), 3'(a), 32'h0);

        // Input held high through reset: rising edge after release not captured
        reset = 1'b1;
        in_port = 4'b0001;
        repeat (2) tick();
        reset = 1'b0;
        repeat (DB + 4) tick();
        rdchk("hold_raw", 3'd1, 32'h1);
        rdchk("hold_data", 3'd0, 32'h1);
        rdchk("hold_cap", 3'd3, 32'h0);

        // Unused bits ignored on write
        wr(3'd2, 32'hFFFF_FFFF);
        rdchk("mask_width", 3'd2, 32'hF);
        wr(3'd4, 32'hFFFF_FFFF);
        rdchk("sel_width", 3'd4, 32'hFF);
        rdchk("unused5", 3'd5, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
